// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - shared state encoding and defaults for the cube sequencer
package acc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RD_WAIT,
    ST_MUL1,
    ST_MUL2,
    ST_WR,
    ST_DONE
  } state_t;

  localparam logic [1:0] FP_OP_MUL = 2'b11;

  localparam int DEF_DEPTH   = 32;
  localparam int DEF_ADDR_W  = 5;
  localparam int DEF_MUL_LAT = 2;

endpackage

// File: rtl/acc_lat_cnt.sv
// rtl/acc_lat_cnt.sv - loadable down-counter timing one multiplier operation
module acc_lat_cnt #(
  parameter int MUL_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expire
);

  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  logic [CW-1:0] lat;

  // Load on entry to a multiply state, then count down and park at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat <= '0;
    end else if (load) begin
      lat <= CW'(MUL_LAT - 1);
    end else if (lat != '0) begin
      lat <= lat - CW'(1);
    end
  end

  // Zero means the current cycle is the last one of the operation.
  assign expire = (lat == '0);

endmodule

// File: rtl/cube_seq_ctrl.sv
// rtl/cube_seq_ctrl.sv - in-place x^3 sequencer over scratch memory; option CUBE_SKIP_ZERO_EN
module cube_seq_ctrl
  import acc_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int MUL_LAT = DEF_MUL_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              host_wen,
  input  logic [31:0]       host_addr,
  input  logic [31:0]       host_din,
  output logic              bsy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout,
  output logic [1:0]        fpu_op,
  output logic [31:0]       fpu_a,
  output logic [31:0]       fpu_b,
  input  logic [31:0]       fpu_dout
);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       x_reg;
  logic [31:0]       sq_reg;
  logic [31:0]       fpu_a_q;
  logic [31:0]       fpu_b_q;
  logic              lat_load;
  logic              lat_expire;
  logic              last;
  logic              skip_now;
  logic              mul_act;
  logic              unused_host_bits;

  assign last     = (idx == ADDR_W'(DEPTH - 1));
  assign mul_act  = (state == ST_MUL1) || (state == ST_MUL2);
  assign fpu_op   = FP_OP_MUL;

  // Byte-address bits outside the word index are deliberately dropped.
  assign unused_host_bits = ^{host_addr[31:ADDR_W+2], host_addr[1:0]};

  acc_lat_cnt #(
    .MUL_LAT (MUL_LAT)
  ) u_lat (
    .clk    (clk),
    .rst    (rst),
    .load   (lat_load),
    .expire (lat_expire)
  );

  // Next-state selection; the counter reloads whenever a multiply state is entered.
  always_comb begin
    state_next = state;
    skip_now   = 1'b0;
    case (state)
      ST_IDLE:    if (start) state_next = ST_RD;
      ST_RD:      state_next = ST_RD_WAIT;
      ST_RD_WAIT: begin
`ifdef CUBE_SKIP_ZERO_EN
        if (mem_dout[30:0] == 31'd0) begin
          skip_now   = 1'b1;
          state_next = last ? ST_DONE : ST_RD;
        end else begin
          state_next = ST_MUL1;
        end
`else
        state_next = ST_MUL1;
`endif
      end
      ST_MUL1:    if (lat_expire) state_next = ST_MUL2;
      ST_MUL2:    if (lat_expire) state_next = ST_WR;
      ST_WR:      state_next = last ? ST_DONE : ST_RD;
      ST_DONE:    state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
    lat_load = ((state_next == ST_MUL1) && (state != ST_MUL1)) ||
               ((state_next == ST_MUL2) && (state != ST_MUL2));
  end

  // State, word index and the registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      idx   <= '0;
      bsy   <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      bsy   <= (state_next != ST_IDLE);
      done  <= (state_next == ST_DONE);
      if (state == ST_IDLE && start) begin
        idx <= '0;
      end else if ((state == ST_WR || skip_now) && !last) begin
        idx <= idx + ADDR_W'(1);
      end
    end
  end

  // Datapath capture: x from memory, x*x from the multiplier, and held operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_reg   <= '0;
      sq_reg  <= '0;
      fpu_a_q <= '0;
      fpu_b_q <= '0;
    end else begin
      if (state == ST_RD_WAIT) x_reg <= mem_dout;
      if (state == ST_MUL1 && lat_expire) sq_reg <= fpu_dout;
      if (mul_act) begin
        fpu_a_q <= fpu_a;
        fpu_b_q <= fpu_b;
      end
    end
  end

  // Operands are live only in the multiply states and hold otherwise.
  always_comb begin
    fpu_a = mul_act ? x_reg : fpu_a_q;
    fpu_b = fpu_b_q;
    if (state == ST_MUL1)      fpu_b = x_reg;
    else if (state == ST_MUL2) fpu_b = sq_reg;
  end

  // Memory port belongs to the host while idle and to the sequencer while busy.
  always_comb begin
    if (bsy) begin
      mem_addr = idx;
      mem_wen  = (state == ST_WR);
      mem_din  = fpu_dout;
    end else begin
      mem_addr = host_addr[ADDR_W+1:2];
      mem_wen  = host_wen;
      mem_din  = host_din;
    end
  end

endmodule
